// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: size/state encodings and request decode shared by the load/store sequencer
package mem_access_ctrl_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD = 2'd1;
  localparam logic [1:0] S_WR = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;
  localparam int TIMEOUT_DEF = 16;
  function automatic logic bad_req(input logic [1:0] size, input logic [1:0] a);
    return size == 2'b11 || (size == SZ_HALF && a[0]) || (size == SZ_WORD && a != 2'b00);
  endfunction
endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: CPU request side and word-wide memory side of the sequencer
interface mem_access_ctrl_if;
  logic cpu_req, cpu_we, cpu_unsigned, cpu_busy, cpu_done, cpu_err;
  logic [1:0] cpu_size;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  modport master (
    input cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_busy, cpu_done, cpu_rdata, cpu_err, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    output cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input cpu_busy, cpu_done, cpu_rdata, cpu_err, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_ctrl_load_extract.sv
// mem_access_ctrl_load_extract: little-endian byte/halfword select with zero or sign extension
module mem_access_ctrl_load_extract
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);
  logic [7:0] b;
  logic [15:0] h;
  assign b = word_i[{addr_i, 3'b000} +: 8];
  assign h = addr_i[1] ? word_i[31:16] : word_i[15:0];
  assign data_o = size_i == SZ_BYTE ? {{24{b[7] & ~unsigned_i}}, b} :
                  size_i == SZ_HALF ? {{16{h[15] & ~unsigned_i}}, h} : word_i;
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: multi-cycle load/store sequencer with read-modify-write stores and timeout
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic clk,
  input logic rst_n,
  mem_access_ctrl_if.master bus
);
  localparam logic [7:0] TO = 8'(TIMEOUT);
  logic [1:0] state_q, state_d, size_q, size_d;
  logic we_q, we_d, uns_q, uns_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, merged, ext;
  logic [7:0] cnt_q, cnt_d;
  mem_access_ctrl_load_extract u_ext (
    .word_i(rdata_q),
    .addr_i(addr_q[1:0]),
    .size_i(size_q),
    .unsigned_i(uns_q),
    .data_o(ext)
  );
  always_comb begin
    merged = bus.mem_rdata;
    if (size_q == SZ_BYTE) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end
  always_comb begin
    state_d = state_q;
    size_d = size_q;
    we_d = we_q;
    uns_d = uns_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d = err_q;
    cnt_d = bus.mem_req && !bus.mem_ack ? cnt_q + 8'd1 : 8'd0;
    case (state_q)
      S_IDLE: if (bus.cpu_req) begin
        size_d = bus.cpu_size;
        we_d = bus.cpu_we;
        uns_d = bus.cpu_unsigned;
        addr_d = bus.cpu_addr;
        wdata_d = bus.cpu_wdata;
        rdata_d = '0;
        err_d = bad_req(bus.cpu_size, bus.cpu_addr[1:0]);
        state_d = err_d ? S_RESP : (bus.cpu_we && bus.cpu_size == SZ_WORD) ? S_WR : S_RD;
      end
      S_RD: if (bus.mem_ack) begin
        rdata_d = bus.mem_rdata;
        wdata_d = merged;
        state_d = we_q ? S_WR : S_RESP;
      end else if (cnt_d == TO) begin
        err_d = 1'b1;
        state_d = S_RESP;
      end
      S_WR: if (bus.mem_ack) state_d = S_RESP;
      else if (cnt_d == TO) begin
        err_d = 1'b1;
        state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= S_IDLE;
      size_q <= '0;
      we_q <= 1'b0;
      uns_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      size_q <= size_d;
      we_q <= we_d;
      uns_q <= uns_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  assign bus.mem_req = state_q == S_RD || state_q == S_WR;
  assign bus.mem_we = state_q == S_WR;
  assign bus.mem_addr = {addr_q[31:2], 2'b00};
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_busy = state_q != S_IDLE;
  assign bus.cpu_done = state_q == S_RESP;
  assign bus.cpu_err = bus.cpu_done & err_q;
  assign bus.cpu_rdata = bus.cpu_done && !we_q && !err_q ? ext : '0;
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Multi-cycle load/store sequencer between the CPU datapath and a word-wide data memory that has no byte enables.
- Accepts one CPU request at a time and issues word-aligned memory reads and writes over a req/ack handshake.
- For loads, extracts the addressed byte or halfword and zero- or sign-extends it.
- For byte and halfword stores, performs read-modify-write.
- Misaligned accesses and memory timeouts are flagged as errors.

Parameters:
- TIMEOUT, 16: maximum number of cycles mem_req may stay high without mem_ack before the access is aborted. Legal range 1..255.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  synchronous active-low reset.
- cpu_req  in  1  request strobe; accepted only when cpu_busy=0.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_size  in  2  00 = byte, 01 = halfword, 10 = word; 11 is illegal and raises an error.
- cpu_unsigned  in  1  load zero-extend when 1, sign-extend when 0.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data, right-justified.
- cpu_busy  out  1  high from the cycle after accept through the cycle of cpu_done.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  load result; valid only with cpu_done.
- cpu_err  out  1  valid only with cpu_done: misaligned access, illegal size, or timeout.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_addr  out  32  word address; bits [1:0] are always 00.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; sampled in the cycle mem_ack=1.
- mem_ack  in  1  memory acknowledge.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
  - While rst_n=0 at an edge: state goes to IDLE; all outputs are 0; the timeout counter clears.
  - Reset mid-transaction discards the transaction. No cpu_done is issued, and mem_req drops at that edge.
- States: IDLE, RD, WR, RESP.
- IDLE: when cpu_req=1, latch the request and decode it.
  - Misaligned or illegal request goes to RESP with err=1 and no memory access. Misaligned means halfword with addr[0]=1, or word with addr[1:0]≠00. Illegal means size=11.
  - Load, or byte/halfword store, goes to RD.
  - Word store goes to WR.
- RD: mem_req=1, mem_we=0, mem_addr={addr[31:2],2'b00}. mem_req and mem_addr are held stable until mem_ack.
  - On mem_ack, capture mem_rdata.
  - Load goes to RESP.
  - Partial store goes to WR with the merged word: replace byte lane addr[1:0] (byte) or halfword lane addr[1] (halfword), little-endian, with wdata[7:0] or wdata[15:0].
- WR: mem_req=1, mem_we=1, mem_wdata = the merged word, or cpu_wdata for a word store. On mem_ack, go to RESP.
- Handshake: mem_req is registered. A transfer completes in the cycle mem_req=1 and mem_ack=1, and mem_req drops at the next edge. mem_ack while mem_req=0 is ignored.
- Load extraction, little-endian:
  - Byte k is data[8k+7:8k].
  - A halfword at addr[1]=h is data[16h+15:16h].
  - Sign is taken from the MSB of the selected field unless cpu_unsigned=1.
  - A word load is passed through unchanged.
- RESP: cpu_done=1 for one cycle, then IDLE.
  - cpu_rdata = the extracted load value; 0 for stores and errors.
  - cpu_busy=1.
  - cpu_req during RESP is ignored. The next request is accepted in IDLE.
- Latency with zero-wait memory (ack in the first mem_req cycle), accept at cycle T:
  - Load: done at T+2.
  - Word store: done at T+2.
  - Partial store: done at T+3.
  - Error: done at T+1.
- Timeout: an 8-bit counter increments each cycle mem_req=1 and mem_ack=0, and clears when a transfer completes.
  - When it reaches TIMEOUT, mem_req drops and the block goes to RESP with err=1 and rdata=0.
  - In a read-modify-write, a timeout in RD skips WR; memory is never written.
- An ack arriving in the same cycle the counter hits TIMEOUT counts as success; the ack takes priority.

Decomposition:
- Shared package holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - state encoding;
  - the TIMEOUT default.
- One natural sub-module: load_extract. It is combinational and takes the word, addr[1:0], size and unsigned, and produces a 32-bit result. It is reused by any later cache or DMA path.
- The byte-lane merge for stores stays inline.

Test Plan:
- Byte load: mem word 0x8899AABB, LB addr 0x103 -> mem_addr 0x100, rdata 0xFFFFFF88. LBU from the same address -> 0x00000088.
- Halfword load: same word, LH addr 0x102 -> 0xFFFF8899. LHU addr 0x100 -> 0x0000AABB. Done at T+2 with zero-wait ack.
- Byte store by read-modify-write: mem 0x11223344, SB addr 0x201, wdata 0xFFFFFFAB -> RD then WR with mem_wdata 0x1122AB44. Done at T+3.
- Misaligned and illegal: LW addr 0x302, SH addr 0x301, and size=11 -> done at T+1 with err=1, rdata 0, mem_req never asserted.
- Wait states and timeout:
  - ack after 5 cycles -> mem_addr held stable for all 5 cycles, then success.
  - No ack -> mem_req drops after 16 cycles and done with err=1.
  - Partial-store timeout -> no write cycle.
- Reset mid-op: rst_n=0 during WR wait -> next edge has mem_req=0, cpu_busy=0, no done. A fresh LW afterward completes normally.
